// File: rtl/alu_operand_stage.sv
// alu_operand_stage: ID/EX pipeline register feeding the ALU.
// Captures decoded operands and bypasses MEM/WB results into them. The stage
// holds while downstream stalls, squashes on flush, and inserts one bubble on a
// load-use hazard.
// Optional build macro ALU_STAGE_STATS_EN adds the bubble_cnt and flush_cnt
// counters.
module alu_operand_stage #(
  parameter int WORD_W  = 32,
  parameter int RADDR_W = 5,
  parameter int OP_W    = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               id_valid,
  input  logic [WORD_W-1:0]  id_rdatA,
  input  logic [WORD_W-1:0]  id_rdatB,
  input  logic [RADDR_W-1:0] id_rs,
  input  logic [RADDR_W-1:0] id_rt,
  input  logic               id_useRt,
  input  logic [OP_W-1:0]    id_ALUOP,
  input  logic [RADDR_W-1:0] id_rd,
  input  logic               id_regWen,
  input  logic               id_memRead,
  input  logic               ex_ready,
  input  logic               flush,
  input  logic               mem_regWen,
  input  logic [RADDR_W-1:0] mem_rd,
  input  logic [WORD_W-1:0]  mem_result,
  input  logic               wb_regWen,
  input  logic [RADDR_W-1:0] wb_rd,
  input  logic [WORD_W-1:0]  wb_result,
  output logic [WORD_W-1:0]  portA,
  output logic [WORD_W-1:0]  portB,
  output logic [OP_W-1:0]    ALUOP,
  output logic               ex_valid,
  output logic [RADDR_W-1:0] ex_rd,
  output logic               ex_regWen,
  output logic               ex_memRead,
`ifdef ALU_STAGE_STATS_EN
  output logic [31:0]        bubble_cnt,
  output logic [31:0]        flush_cnt,
`endif
  output logic               id_stall
);

  logic [WORD_W-1:0]  a_q, b_q;
  logic [RADDR_W-1:0] rs_q, rt_q, rd_q;
  logic               use_rt_q, regwen_q, memread_q, valid_q;
  logic [OP_W-1:0]    aluop_q;

  logic hz;
  logic wb_ok, mem_ok;
  logic wb_hit_a_q, wb_hit_b_q, mem_hit_a_q, mem_hit_b_q;
  logic wb_hit_a_id, wb_hit_b_id;

  // Sideband outputs; write-enable and load flags are meaningless without valid.
  always_comb begin
    ex_valid   = valid_q;
    ex_rd      = rd_q;
    ex_regWen  = valid_q & regwen_q;
    ex_memRead = valid_q & memread_q;
    ALUOP      = aluop_q;
  end

  // Writer match detection; register 0 never matches.
  always_comb begin
    wb_ok       = wb_regWen & (wb_rd != '0);
    mem_ok      = mem_regWen & (mem_rd != '0);
    wb_hit_a_q  = wb_ok & (wb_rd == rs_q);
    wb_hit_b_q  = wb_ok & use_rt_q & (wb_rd == rt_q);
    mem_hit_a_q = mem_ok & (mem_rd == rs_q);
    mem_hit_b_q = mem_ok & use_rt_q & (mem_rd == rt_q);
    wb_hit_a_id = wb_ok & (wb_rd == id_rs);
    wb_hit_b_id = wb_ok & id_useRt & (wb_rd == id_rt);
  end

  // Load-use hazard and decode stall; flush overrides any stall.
  always_comb begin
    hz = ex_valid & ex_memRead & ex_regWen & (ex_rd != '0) & id_valid &
         ((id_rs == ex_rd) | (id_useRt & (id_rt == ex_rd)));
    id_stall = ~RST & ~flush & (hz | ~ex_ready);
  end

  // Operand forwarding on the stored value: MEM beats WB, which beats the stored value.
  always_comb begin
    portA = mem_hit_a_q ? mem_result : (wb_hit_a_q ? wb_result : a_q);
    portB = mem_hit_b_q ? mem_result : (wb_hit_b_q ? wb_result : b_q);
  end

  // Stage register: flush > hold (with WB refresh) > bubble > capture.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_q       <= '0;
      b_q       <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      use_rt_q  <= 1'b0;
      regwen_q  <= 1'b0;
      memread_q <= 1'b0;
      valid_q   <= 1'b0;
      aluop_q   <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (!ex_ready) begin
      if (wb_hit_a_q) a_q <= wb_result;
      if (wb_hit_b_q) b_q <= wb_result;
    end else if (hz) begin
      valid_q   <= 1'b0;
      regwen_q  <= 1'b0;
      memread_q <= 1'b0;
    end else begin
      valid_q   <= id_valid;
      rs_q      <= id_rs;
      rt_q      <= id_rt;
      rd_q      <= id_rd;
      use_rt_q  <= id_useRt;
      regwen_q  <= id_regWen;
      memread_q <= id_memRead;
      aluop_q   <= id_ALUOP;
      a_q       <= wb_hit_a_id ? wb_result : id_rdatA;
      b_q       <= wb_hit_b_id ? wb_result : id_rdatB;
    end
  end

`ifdef ALU_STAGE_STATS_EN
  // Event counters: bubbles inserted and valid instructions squashed.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (!flush && ex_ready && hz) bubble_cnt <= bubble_cnt + 32'd1;
      if (flush && valid_q)         flush_cnt  <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage with hand-computed expectations.
module tb_alu_operand_stage;
  logic        CLK = 1'b0;
  logic        RST;
  logic        id_valid, id_useRt, id_regWen, id_memRead, ex_ready, flush;
  logic [31:0] id_rdatA, id_rdatB, mem_result, wb_result;
  logic [4:0]  id_rs, id_rt, id_rd, mem_rd, wb_rd, ex_rd;
  logic [3:0]  id_ALUOP, ALUOP;
  logic        mem_regWen, wb_regWen;
  logic [31:0] portA, portB;
  logic        ex_valid, ex_regWen, ex_memRead, id_stall;
`ifdef ALU_STAGE_STATS_EN
  logic [31:0] bubble_cnt, flush_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  alu_operand_stage dut (
    .CLK(CLK), .RST(RST),
    .id_valid(id_valid), .id_rdatA(id_rdatA), .id_rdatB(id_rdatB),
    .id_rs(id_rs), .id_rt(id_rt), .id_useRt(id_useRt), .id_ALUOP(id_ALUOP),
    .id_rd(id_rd), .id_regWen(id_regWen), .id_memRead(id_memRead),
    .ex_ready(ex_ready), .flush(flush),
    .mem_regWen(mem_regWen), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_regWen(wb_regWen), .wb_rd(wb_rd), .wb_result(wb_result),
    .portA(portA), .portB(portB), .ALUOP(ALUOP),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_regWen(ex_regWen),
    .ex_memRead(ex_memRead),
`ifdef ALU_STAGE_STATS_EN
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt),
`endif
    .id_stall(id_stall)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rdatA = 0; id_rdatB = 0; id_rs = 0; id_rt = 0;
    id_useRt = 0; id_ALUOP = 0; id_rd = 0; id_regWen = 0; id_memRead = 0;
    ex_ready = 1; flush = 0;
    mem_regWen = 0; mem_rd = 0; mem_result = 0;
    wb_regWen = 0; wb_rd = 0; wb_result = 0;
  endtask

  task automatic issue(input logic [4:0] rs, input logic [31:0] a,
                       input logic [4:0] rt, input logic [31:0] b, input logic use_rt,
                       input logic [3:0] op, input logic [4:0] rd,
                       input logic wen, input logic mrd);
    id_valid = 1; id_rs = rs; id_rdatA = a; id_rt = rt; id_rdatB = b;
    id_useRt = use_rt; id_ALUOP = op; id_rd = rd; id_regWen = wen; id_memRead = mrd;
  endtask

  initial begin
    idle();
    RST = 1;
    ex_ready = 0;
    #3;
    chk("rst_portA", portA, 32'h0);
    chk("rst_portB", portB, 32'h0);
    chk("rst_aluop", {28'h0, ALUOP}, 32'h0);
    chk("rst_valid", {31'h0, ex_valid}, 32'h0);
    chk("rst_stall", {31'h0, id_stall}, 32'h0);
    tick();
    tick();
    ex_ready = 1;
    RST = 0;

    // MEM vs WB priority on portA
    issue(5'd3, 32'h11, 5'd6, 32'h22, 1'b1, 4'h5, 5'd7, 1'b1, 1'b0);
    tick();
    idle();
    ex_ready = 0;
    mem_regWen = 1; mem_rd = 5'd3; mem_result = 32'hAAAA0000;
    wb_regWen = 1; wb_rd = 5'd3; wb_result = 32'h5555;
    #1;
    chk("cap_valid", {31'h0, ex_valid}, 32'h1);
    chk("cap_aluop", {28'h0, ALUOP}, 32'h5);
    chk("cap_rd", {27'h0, ex_rd}, 32'h7);
    chk("cap_portB", portB, 32'h22);
    chk("prio_mem", portA, 32'hAAAA0000);
    mem_regWen = 0;
    #1;
    chk("prio_wb", portA, 32'h5555);
    wb_regWen = 0;
    #1;
    chk("prio_stored", portA, 32'h11);
    ex_ready = 1;

    // Load-use hazard: one stall cycle, one bubble, then capture
    issue(5'd1, 32'h100, 5'd0, 32'h4, 1'b0, 4'h0, 5'd8, 1'b1, 1'b1);
    tick();
    chk("lw_memread", {31'h0, ex_memRead}, 32'h1);
    issue(5'd8, 32'hDEAD, 5'd2, 32'h7, 1'b1, 4'h1, 5'd9, 1'b1, 1'b0);
    #1;
    chk("lu_stall", {31'h0, id_stall}, 32'h1);
    tick();
    mem_regWen = 1; mem_rd = 5'd8; mem_result = 32'hCAFE0000;
    #1;
    chk("lu_bubble_valid", {31'h0, ex_valid}, 32'h0);
    chk("lu_bubble_wen", {31'h0, ex_regWen}, 32'h0);
    chk("lu_stall_clear", {31'h0, id_stall}, 32'h0);
    tick();
    id_valid = 0;
    mem_regWen = 0;
    wb_regWen = 1; wb_rd = 5'd8; wb_result = 32'hCAFE0000;
    #1;
    chk("lu_add_valid", {31'h0, ex_valid}, 32'h1);
    chk("lu_add_portA", portA, 32'hCAFE0000);
    chk("lu_add_portB", portB, 32'h7);
    chk("lu_add_aluop", {28'h0, ALUOP}, 32'h1);
    wb_regWen = 0;

    // Hold with WB refresh of the stored rt operand
    issue(5'd0, 32'h50, 5'd4, 32'h9, 1'b1, 4'h2, 5'd10, 1'b1, 1'b0);
    tick();
    issue(5'd11, 32'h0, 5'd12, 32'h0, 1'b1, 4'h3, 5'd13, 1'b1, 1'b0);
    ex_ready = 0;
    wb_regWen = 1; wb_rd = 5'd4; wb_result = 32'h1234;
    #1;
    chk("hold_stall1", {31'h0, id_stall}, 32'h1);
    tick();
    wb_regWen = 0;
    #1;
    chk("hold_stall2", {31'h0, id_stall}, 32'h1);
    chk("hold_refresh", portB, 32'h1234);
    tick();
    chk("hold_stall3", {31'h0, id_stall}, 32'h1);
    tick();
    ex_ready = 1;
    #1;
    chk("rel_portB", portB, 32'h1234);
    chk("rel_portA", portA, 32'h50);
    chk("rel_rd", {27'h0, ex_rd}, 32'hA);
    chk("rel_stall", {31'h0, id_stall}, 32'h0);

    // Flush with simultaneous stall and hazard
    issue(5'd1, 32'h0, 5'd0, 32'h0, 1'b0, 4'h0, 5'd12, 1'b1, 1'b1);
    tick();
    issue(5'd12, 32'h0, 5'd0, 32'h0, 1'b0, 4'h6, 5'd14, 1'b1, 1'b0);
    ex_ready = 0;
    #1;
    chk("fl_pre_stall", {31'h0, id_stall}, 32'h1);
    flush = 1;
    #1;
    chk("fl_stall", {31'h0, id_stall}, 32'h0);
    tick();
    chk("fl_valid", {31'h0, ex_valid}, 32'h0);
    chk("fl_wen", {31'h0, ex_regWen}, 32'h0);
    idle();

    // Immediate operand and register 0
    issue(5'd0, 32'h3, 5'd5, 32'h77, 1'b0, 4'h7, 5'd15, 1'b1, 1'b0);
    wb_regWen = 1; wb_rd = 5'd0; wb_result = 32'hBAD;
    tick();
    id_valid = 0;
    ex_ready = 0;
    mem_regWen = 1; mem_rd = 5'd5; mem_result = 32'hF00D;
    #1;
    chk("imm_portB", portB, 32'h77);
    chk("r0_wb_portA", portA, 32'h3);
    mem_rd = 5'd0; mem_result = 32'hBAD;
    #1;
    chk("r0_mem_portA", portA, 32'h3);
    idle();

    // WB bypass into capture, then asynchronous reset mid-run
    issue(5'd6, 32'h1, 5'd0, 32'h0, 1'b0, 4'h9, 5'd2, 1'b1, 1'b0);
    wb_regWen = 1; wb_rd = 5'd6; wb_result = 32'h66;
    tick();
    idle();
    ex_ready = 0;
    #1;
    chk("cap_bypass", portA, 32'h66);
    chk("pre_rst_valid", {31'h0, ex_valid}, 32'h1);
    RST = 1;
    #1;
    chk("arst_valid", {31'h0, ex_valid}, 32'h0);
    chk("arst_portA", portA, 32'h0);
    chk("arst_portB", portB, 32'h0);
    chk("arst_aluop", {28'h0, ALUOP}, 32'h0);
    chk("arst_stall", {31'h0, id_stall}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- ID/EX pipeline stage that sits directly upstream of the ALU; drives the ALU's portA, portB and ALUOP.
- Captures decoded operands, bypasses MEM/WB results into them, holds on downstream stall, squashes on flush.
- Detects load-use hazards and inserts one bubble while stalling decode.

Parameters:
WORD_W, 32, datapath width (matches word_t)
RADDR_W, 5, register index width
OP_W, 4, ALU opcode width

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous reset, active-high
id_valid  in  1  decode holds a valid instruction
id_rdatA  in  WORD_W  register-file read of rs
id_rdatB  in  WORD_W  register-file read of rt, or immediate
id_rs  in  RADDR_W  source A index
id_rt  in  RADDR_W  source B index
id_useRt  in  1  1: portB from rt register; 0: immediate (never forwarded)
id_ALUOP  in  OP_W  ALU opcode
id_rd  in  RADDR_W  destination index
id_regWen  in  1  instruction writes rd
id_memRead  in  1  instruction is a load
ex_ready  in  1  downstream accepts this cycle; 0 = hold
flush  in  1  squash stage contents (branch/jump)
mem_regWen, mem_rd, mem_result  in  1/RADDR_W/WORD_W  EX/MEM writeback info
wb_regWen, wb_rd, wb_result  in  1/RADDR_W/WORD_W  MEM/WB writeback info
portA, portB  out  WORD_W  ALU operands
ALUOP  out  OP_W  ALU opcode
ex_valid, ex_rd, ex_regWen, ex_memRead  out  1/RADDR_W/1/1  stage sideband
id_stall  out  1  decode must hold its instruction

Behaviour:
- Reset (async, RST=1): all stored fields zero, ex_valid=0; portA=portB=0, ALUOP=0, id_stall=0.
- Hazard: hz = ex_valid & ex_memRead & ex_regWen & ex_rd!=0 & id_valid & (id_rs==ex_rd | (id_useRt & id_rt==ex_rd)).
- id_stall = ~flush & (hz | ~ex_ready).
- Rising edge, priority order:
  1. flush: ex_valid<=0; other fields don't-care (zeroing is permitted).
  2. ~ex_ready: hold all fields; refresh stored A (and B if useRt) with wb_result when wb_regWen & wb_rd!=0 & wb_rd matches the stored index.
  3. hz: bubble; ex_valid<=0, ex_regWen<=0, ex_memRead<=0.
  4. else: capture all id_* fields, ex_valid<=id_valid; stored A/B take wb_result if a WB match exists (same rules as refresh), else id_rdat*.
- Output forwarding (combinational on the stored value), per operand:
  - MEM match (mem_regWen, mem_rd!=0, index equal) beats WB match, which beats the stored value.
  - portB is forwarded only if the stored useRt=1.
- Register 0 is never forwarded or hazarded.
- ALUOP is the registered opcode.
- Latency: one cycle from ID capture to ALU inputs; hazard costs exactly one bubble.
- ex_valid=0: ex_regWen and ex_memRead outputs are gated to 0.

Optional Feature:
- ALU_STAGE_STATS_EN defined adds two outputs:
  - bubble_cnt[31:0]: increments each edge that takes branch 3.
  - flush_cnt[31:0]: increments each edge with flush & ex_valid.
  - Both clear on RST and wrap at 2^32.
- Undefined: outputs and counters absent; behaviour otherwise identical.

Test Plan:
- Reset mid-run: RST=1 async while ex_valid=1 -> ex_valid, portA, portB, ALUOP go 0 immediately, without waiting for a CLK edge.
- MEM vs WB priority: stored rs=3; mem_rd=3 with 0xAAAA0000, wb_rd=3 with 0x5555 -> portA=0xAAAA0000; drop mem_regWen -> portA=0x5555.
- Load-use: EX holds lw to r8, ID add uses r8 -> id_stall=1 for one cycle, then ex_valid=0 bubble, then add captured; portA = mem_result of the load.
- Hold with refresh: ex_ready=0 for 3 cycles; wb writes r4=0x1234 in cycle 1, stored rt=4 -> after release portB=0x1234; id_stall=1 for all 3 cycles.
- Flush vs stall: flush=1 with ex_ready=0 and hz=1 simultaneously -> ex_valid=0 next cycle, id_stall=0.
- Immediate with r0: id_useRt=0, id_rt=5, mem_rd=5 -> portB = immediate; any write to r0 is never forwarded (portA stays stored value).
